// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing constants and capture FSM state codes,
// used by the capture block and by the pattern generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_800 = 800;
  localparam int H_FP_800     = 40;
  localparam int H_SYNC_800   = 128;
  localparam int H_BP_800     = 88;
  localparam int V_ACTIVE_600 = 600;
  localparam int V_FP_600     = 1;
  localparam int V_SYNC_600   = 4;
  localparam int V_BP_600     = 23;

  typedef logic [1:0] vga_state_t;

  localparam vga_state_t ST_SEARCH = 2'd0;
  localparam vga_state_t ST_HLOCK  = 2'd1;
  localparam vga_state_t ST_LOCKED = 2'd2;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop synchronizer with rising-edge detect. The edge reference only
// advances when i_en is high, so a signal can be compared at sparse sample points.
module vga_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  input  logic i_en,
  output logic o_rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_en ? sync_q : prev_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q & ~prev_q;

endmodule

// File: rtl/vga_capture_800x600.sv
// VGA capture: locks to incoming sync timing and emits one downscaled
// pixel per SCALE x SCALE block.
//   state     | meaning
//   SEARCH    | counting consecutive correct line periods
//   HLOCK     | line timing good, waiting for the first vsync-rise line
//   LOCKED    | frame timing verified, pixels are captured
import vga_timing_pkg::*;

module vga_capture_800x600 #(
  parameter int H_ACTIVE     = H_ACTIVE_800,
  parameter int H_FP         = H_FP_800,
  parameter int H_SYNC       = H_SYNC_800,
  parameter int H_BP         = H_BP_800,
  parameter int V_ACTIVE     = V_ACTIVE_600,
  parameter int V_FP         = V_FP_600,
  parameter int V_SYNC       = V_SYNC_600,
  parameter int V_BP         = V_BP_600,
  parameter int SCALE        = 4,
  parameter int SAMPLE_PHASE = 2,
  parameter int LOCK_LINES   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_red,
  input  logic [1:0] i_green,
  input  logic [1:0] i_blue,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic [5:0] o_pixel,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_pix_valid,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_OFF   = H_SYNC + H_BP;
  localparam int V_OFF   = V_SYNC + V_BP;
  localparam int SH      = $clog2(SCALE);
  localparam logic [10:0] H_MASK    = 11'(SCALE - 1);
  localparam logic [9:0]  V_MASK    = 10'(SCALE - 1);
  localparam logic [10:0] H_PH      = 11'(SAMPLE_PHASE);
  localparam logic [9:0]  V_PH      = 10'(SAMPLE_PHASE);
  localparam logic [7:0]  LOCK_INIT = 8'(LOCK_LINES);

  logic        hs_rise, vs_rise, v_line;
  logic [5:0]  rgb_s1_q, rgb_s2_q;
  logic [10:0] hcnt_q, hcnt_d, ax;
  logic [9:0]  vcnt_q, vcnt_d, ay;
  logic [7:0]  lines_left_q, lines_left_d;
  vga_state_t  state_q, state_d;
  logic        h_ok, v_ok, h_sat, mismatch, h_in, v_in, strobe;
  logic [5:0]  pixel_q, pixel_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        valid_q, fs_q, fs_d, err_q;

  vga_edge_sync u_hsync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_hsync),
    .i_en    (1'b1),
    .o_rise  (hs_rise)
  );

  // vsync is only compared between successive hsync rises
  vga_edge_sync u_vsync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_vsync),
    .i_en    (hs_rise),
    .o_rise  (vs_rise)
  );

  always_comb begin
    v_line = hs_rise & vs_rise;
    hcnt_d = hs_rise ? 11'd0 : ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1);
    vcnt_d = v_line ? 10'd0 : (hs_rise ? vcnt_q + 10'd1 : vcnt_q);
    h_ok   = (12'(hcnt_q) + 12'd1) == 12'(H_TOTAL);
    v_ok   = (11'(vcnt_q) + 11'd1) == 11'(V_TOTAL);
    h_sat  = !hs_rise && (hcnt_q == 11'h7FE);

    mismatch = (state_q != ST_SEARCH) &&
               ((hs_rise && !h_ok) || h_sat || ((state_q == ST_LOCKED) && v_line && !v_ok));

    state_d      = state_q;
    lines_left_d = lines_left_q;
    if (mismatch) begin
      state_d      = ST_SEARCH;
      lines_left_d = LOCK_INIT;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (hs_rise) begin
            if (!h_ok) begin
              lines_left_d = LOCK_INIT;
            end else if (lines_left_q <= 8'd1) begin
              state_d      = ST_HLOCK;
              lines_left_d = LOCK_INIT;
            end else begin
              lines_left_d = lines_left_q - 8'd1;
            end
          end
        end
        ST_HLOCK:  if (v_line) state_d = ST_LOCKED;
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_SEARCH;
      endcase
    end

    fs_d = v_line && !mismatch && (state_q != ST_SEARCH);

    ax     = hcnt_d - 11'(H_OFF);
    ay     = vcnt_d - 10'(V_OFF);
    h_in   = (hcnt_d >= 11'(H_OFF)) && (hcnt_d < 11'(H_OFF + H_ACTIVE));
    v_in   = (vcnt_d >= 10'(V_OFF)) && (vcnt_d < 10'(V_OFF + V_ACTIVE));
    strobe = (state_q == ST_LOCKED) && !mismatch && h_in && v_in &&
             ((ax & H_MASK) == H_PH) && ((ay & V_MASK) == V_PH);

    pixel_d = strobe ? rgb_s2_q : pixel_q;
    x_d     = strobe ? 8'(ax >> SH) : x_q;
    y_d     = strobe ? 8'(ay >> SH) : y_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_s1_q     <= '0;
      rgb_s2_q     <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      lines_left_q <= LOCK_INIT;
      state_q      <= ST_SEARCH;
      pixel_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      fs_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rgb_s1_q     <= {i_red, i_green, i_blue};
      rgb_s2_q     <= rgb_s1_q;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      lines_left_q <= lines_left_d;
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      valid_q      <= strobe;
      fs_q         <= fs_d;
      err_q        <= mismatch;
    end
  end

  assign o_pixel       = pixel_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_pix_valid   = valid_q;
  assign o_frame_start = fs_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_err         = err_q;

endmodule

// File: doc/vga_capture_800x600.md
VGA_CAPTURE_800X600 -- requirements
Module: vga_capture_800x600

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC and H_BP, defaults 40/128/88: horizontal porch and sync widths in clocks (H_TOTAL = 1056).
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 600/1/4/23: vertical porch and sync widths in lines (V_TOTAL = 628).
REQ-004 SHALL have parameter SCALE, default 4: downscale factor per axis, power of two.
REQ-005 SHALL have parameter SAMPLE_PHASE, default 2: sampled pixel offset inside each SCALE×SCALE block, range 0..SCALE-1.
REQ-006 SHALL have parameter LOCK_LINES, default 4: consecutive correct line periods required for horizontal lock.
REQ-007 i_clk  in  1  pixel clock, 40 MHz, one pixel per clock; only clock.
REQ-008 i_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_red, i_green, i_blue  in  2 each  incoming colour.
REQ-010 i_hsync, i_vsync  in  1 each  incoming syncs, active-high.
REQ-011 o_pixel  out  6  captured {red, green, blue}.
REQ-012 o_x  out  8  downscaled column, 0..H_ACTIVE/SCALE-1.
REQ-013 o_y  out  8  downscaled row, 0..V_ACTIVE/SCALE-1.
REQ-014 o_pix_valid  out  1  one-clock strobe qualifying o_pixel, o_x and o_y.
REQ-015 o_frame_start  out  1  one-clock pulse at vertical lock point.
REQ-016 o_locked  out  1  high in LOCKED state.
REQ-017 o_err  out  1  one-clock pulse on timing mismatch.

Function
REQ-018 SHALL register all inputs through two flop stages; all timing below is referenced to the stage-2 signals.
REQ-019 SHALL detect an hsync rising edge when stage-2 hsync is 1 and its previous value was 0.
REQ-020 SHALL run an 11-bit hcnt: 0 on the hsync-rise clock, +1 otherwise, saturating at 2047.
REQ-021 SHALL form the line period as hcnt+1 at each hsync rise; a period equal to H_TOTAL is correct, any other value is a mismatch.
REQ-022 SHALL sample vsync at each hsync rise; a vsync-rise line is one where vsync is 1 and was 0 at the previous hsync rise.
REQ-023 SHALL run a 10-bit vcnt: 0 on a vsync-rise line, +1 on every other hsync rise.
REQ-024 SHALL implement FSM SEARCH → HLOCK → LOCKED.
- SEARCH: after LOCK_LINES consecutive correct periods → HLOCK.
- HLOCK: on vsync-rise line → LOCKED; o_frame_start pulses on that clock.
- LOCKED: at every vsync-rise line, vcnt prior value +1 must equal V_TOTAL.
REQ-025 SHALL treat as a mismatch, in HLOCK or LOCKED: a bad line period, hcnt saturating, or (LOCKED only) a bad frame length; on mismatch → SEARCH, clear the consecutive-line count, pulse o_err once.
REQ-026 SHALL take the mismatch path when a mismatch and a vsync-rise coincide.
REQ-027 SHALL define active region ax = hcnt-(H_SYNC+H_BP) in 0..H_ACTIVE-1 and ay = vcnt-(V_SYNC+V_BP) in 0..V_ACTIVE-1.
REQ-028 SHALL, in LOCKED with ax%SCALE == SAMPLE_PHASE and ay%SCALE == SAMPLE_PHASE, register o_pixel = stage-2 RGB, o_x = ax/SCALE, o_y = ay/SCALE and pulse o_pix_valid; latency from input pin to o_pix_valid is 3 clocks.
REQ-029 SHALL hold o_pixel, o_x and o_y between strobes; o_pix_valid is never asserted outside LOCKED.

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously clear all outputs, counters and synchronizer flops and enter SEARCH.
REQ-031 SHALL require a mid-frame reset to restart lock acquisition, with no partial strobes emitted after release.

Structure
REQ-032 SHALL place the FSM state enum and the 800x600@60 timing constants in shared package vga_timing_pkg, reused by the generator.
REQ-033 SHALL instantiate one sub-module vga_edge_sync (2-flop synchronizer plus rising-edge detect) for hsync and vsync.

Verification
REQ-034 Drive the 800x600x60 down-4x4 generator output → o_locked high within 2 frames; exactly 30000 o_pix_valid per frame; o_frame_start once per 663168 clocks.
REQ-035 Generator colour = f(x,y) pattern → every strobe has o_pixel == f(o_x,o_y); first strobe o_x=0,o_y=0; last strobe o_x=199,o_y=149.
REQ-036 In LOCKED, stretch one line to 1057 clocks → o_err single pulse, o_locked low 3 clocks after the bad hsync rise, no strobes until relock.
REQ-037 Drop one vsync pulse → o_err at the next vsync-rise line (frame length 1256); relock on the following frame.
REQ-038 Assert i_rst_n low mid-line for 3 clocks → all outputs 0 immediately; lock reacquired within 2 frames.
REQ-039 Hold hsync low → hcnt saturates; no lock, o_pix_valid stays 0.
